// File: rtl/cam_ctrl_pkg.sv
// rtl/cam_ctrl_pkg.sv - shared state type, readout step constants and strobe decode for cam_ctrl_fsm
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2
  } cam_state_t;

  localparam int         RD_STEPS      = 8;
  localparam logic [2:0] RD_LAST_STEP  = 3'(RD_STEPS - 1);
  localparam logic [2:0] NRE1_LO_FIRST = 3'd0;
  localparam logic [2:0] NRE1_LO_LAST  = 3'd2;
  localparam logic [2:0] ADC1_STEP     = 3'd1;
  localparam logic [2:0] NRE2_LO_FIRST = 3'd4;
  localparam logic [2:0] NRE2_LO_LAST  = 3'd6;
  localparam logic [2:0] ADC2_STEP     = 3'd5;

  function automatic logic in_range(input logic [2:0] s, input logic [2:0] lo, input logic [2:0] hi);
    return (s >= lo) && (s <= hi);
  endfunction

  // Returns {NRE_1, NRE_2, ADC} for a readout step; NRE lines are active low.
  function automatic logic [2:0] rd_decode(input logic [2:0] step);
    logic nre1_lo;
    logic nre2_lo;
    logic adc;
    nre1_lo = in_range(step, NRE1_LO_FIRST, NRE1_LO_LAST);
    nre2_lo = in_range(step, NRE2_LO_FIRST, NRE2_LO_LAST);
    adc     = (step == ADC1_STEP) || (step == ADC2_STEP);
    return {~nre1_lo, ~nre2_lo, adc};
  endfunction

endpackage

// File: rtl/cam_ctrl_if.sv
// rtl/cam_ctrl_if.sv - capture request / array strobe bundle; Abort exists only with CAM_CTRL_ABORT_EN
interface cam_ctrl_if #(parameter int TW = 5);

  logic          Init;
  logic [TW-1:0] EX_time;
  logic          Erase;
  logic          Expose;
  logic          NRE_1;
  logic          NRE_2;
  logic          ADC;
  logic          Busy;

`ifdef CAM_CTRL_ABORT_EN
  logic          Abort;

  modport master (output Init, EX_time, Abort,
                  input  Erase, Expose, NRE_1, NRE_2, ADC, Busy);
  modport slave  (input  Init, EX_time, Abort,
                  output Erase, Expose, NRE_1, NRE_2, ADC, Busy);
`else
  modport master (output Init, EX_time,
                  input  Erase, Expose, NRE_1, NRE_2, ADC, Busy);
  modport slave  (input  Init, EX_time,
                  output Erase, Expose, NRE_1, NRE_2, ADC, Busy);
`endif

endinterface

// File: rtl/cam_readout_seq.sv
// rtl/cam_readout_seq.sv - 8-step readout sequencer driving registered NRE_1, NRE_2 and ADC
module cam_readout_seq
  import cam_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_go,
  input  logic i_clr,
  output logic o_nre_1,
  output logic o_nre_2,
  output logic o_adc,
  output logic o_done
);

  logic       r_active;
  logic [2:0] r_step;
  logic [2:0] r_strb;

  // Strobes are loaded with the decode of the step they will be shown in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_step   <= 3'd0;
      r_strb   <= 3'b110;
    end else if (i_clr) begin
      r_active <= 1'b0;
      r_step   <= 3'd0;
      r_strb   <= 3'b110;
    end else if (i_go) begin
      r_active <= 1'b1;
      r_step   <= 3'd0;
      r_strb   <= rd_decode(3'd0);
    end else if (r_active) begin
      if (r_step == RD_LAST_STEP) begin
        r_active <= 1'b0;
        r_step   <= 3'd0;
        r_strb   <= 3'b110;
      end else begin
        r_step   <= r_step + 3'd1;
        r_strb   <= rd_decode(r_step + 3'd1);
      end
    end
  end

  assign o_nre_1 = r_strb[2];
  assign o_nre_2 = r_strb[1];
  assign o_adc   = r_strb[0];
  assign o_done  = r_active && (r_step == RD_LAST_STEP);

endmodule

// File: rtl/cam_ctrl_fsm.sv
// rtl/cam_ctrl_fsm.sv - capture sequencer IDLE -> EXPOSE -> READOUT; optional abort via CAM_CTRL_ABORT_EN
module cam_ctrl_fsm
  import cam_ctrl_pkg::*;
#(
  parameter int TW      = 5,
  parameter int EXP_MIN = 2,
  parameter int EXP_MAX = 30
) (
  input  logic      clk,
  input  logic      reset,
  cam_ctrl_if.slave bus
);

  cam_state_t    r_state;
  cam_state_t    w_state_nxt;
  logic          r_init_q;
  logic          w_start;
  logic          w_abort;
  logic          w_go;
  logic          w_rd_done;
  logic [TW-1:0] r_exp_cnt;
  logic [TW-1:0] w_n;
  logic          r_erase;
  logic          r_expose;
  logic          r_busy;
  logic          w_erase_nxt;
  logic          w_expose_nxt;
  logic          w_busy_nxt;
  logic          w_nre_1;
  logic          w_nre_2;
  logic          w_adc;

  assign w_start = bus.Init & ~r_init_q;

`ifdef CAM_CTRL_ABORT_EN
  assign w_abort = bus.Abort & (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_go = (r_state == EXPOSE) && (r_exp_cnt == '0) && !w_abort;

  always_comb begin
    w_n = bus.EX_time;
    if (bus.EX_time < TW'(EXP_MIN))
      w_n = TW'(EXP_MIN);
    else if (bus.EX_time > TW'(EXP_MAX))
      w_n = TW'(EXP_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_init_q <= 1'b0;
    else
      r_init_q <= bus.Init;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = EXPOSE;
      EXPOSE:  if (r_exp_cnt == '0) w_state_nxt = READOUT;
      READOUT: if (w_rd_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort)
      w_state_nxt = IDLE;
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_comb begin
    w_erase_nxt  = (w_state_nxt == IDLE);
    w_expose_nxt = (w_state_nxt == EXPOSE);
    w_busy_nxt   = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_erase  <= 1'b1;
      r_expose <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_erase  <= w_erase_nxt;
      r_expose <= w_expose_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Loaded with N-1 so that Expose stays high for exactly N cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_exp_cnt <= '0;
    else if (w_abort)
      r_exp_cnt <= '0;
    else if ((r_state == IDLE) && w_start)
      r_exp_cnt <= w_n - TW'(1);
    else if ((r_state == EXPOSE) && (r_exp_cnt != '0))
      r_exp_cnt <= r_exp_cnt - TW'(1);
  end

  cam_readout_seq u_readout (
    .clk     (clk),
    .reset   (reset),
    .i_go    (w_go),
    .i_clr   (w_abort),
    .o_nre_1 (w_nre_1),
    .o_nre_2 (w_nre_2),
    .o_adc   (w_adc),
    .o_done  (w_rd_done)
  );

  assign bus.Erase  = r_erase;
  assign bus.Expose = r_expose;
  assign bus.Busy   = r_busy;
  assign bus.NRE_1  = w_nre_1;
  assign bus.NRE_2  = w_nre_2;
  assign bus.ADC    = w_adc;

endmodule

// File: tb/tb_cam_ctrl_fsm.sv
// tb/tb_cam_ctrl_fsm.sv - directed self-checking bench for cam_ctrl_fsm (abort cases with CAM_CTRL_ABORT_EN)
module tb_cam_ctrl_fsm;

  localparam int TW = 5;
  // {Erase, Expose, NRE_1, NRE_2, ADC, Busy}
  localparam logic [5:0] IDLE_VEC   = 6'b101100;
  localparam logic [5:0] EXPOSE_VEC = 6'b011101;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   width;
  int   cnt;
  logic [2:0] rd_tab [8];

  cam_ctrl_if #(.TW(TW)) bus ();

  cam_ctrl_fsm #(.TW(TW), .EXP_MIN(2), .EXP_MAX(30)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.Erase, bus.Expose, bus.NRE_1, bus.NRE_2, bus.ADC, bus.Busy});
  endfunction

  // Ensures Init is sampled low once, raises it, and returns just after the start edge.
  task automatic start_capture(input int ex);
    @(posedge clk); #1;
    bus.Init    = 1'b0;
    bus.EX_time = TW'(ex);
    @(posedge clk); #1;
    bus.Init    = 1'b1;
    @(posedge clk);
  endtask

  task automatic measure_expose(input int ex_mid, output int w);
    w = 0;
    @(negedge clk);
    while (bus.Expose === 1'b1 && w < 40) begin
      w++;
      if (w == 2 && ex_mid >= 0)
        bus.EX_time = TW'(ex_mid);
      @(negedge clk);
    end
  endtask

  task automatic check_readout(input string tag);
    for (int s = 0; s < 8; s++) begin
      check($sformatf("%s_rd%0d", tag, s), int'({bus.NRE_1, bus.NRE_2, bus.ADC}), int'(rd_tab[s]));
      @(negedge clk);
    end
    check($sformatf("%s_idle", tag), outs(), int'(IDLE_VEC));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rd_tab[0] = 3'b010; rd_tab[1] = 3'b011; rd_tab[2] = 3'b010; rd_tab[3] = 3'b110;
    rd_tab[4] = 3'b100; rd_tab[5] = 3'b101; rd_tab[6] = 3'b100; rd_tab[7] = 3'b110;

    reset       = 1'b1;
    bus.Init    = 1'b0;
    bus.EX_time = '0;
`ifdef CAM_CTRL_ABORT_EN
    bus.Abort   = 1'b0;
`endif
    #2;
    check("reset_vals", outs(), int'(IDLE_VEC));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset in the middle of an exposure cycle
    start_capture(5);
    @(negedge clk);
    check("expose_c1", outs(), int'(EXPOSE_VEC));
    #2 reset = 1'b1;
    #1 check("async_reset", outs(), int'(IDLE_VEC));
    bus.Init = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Nominal capture, EX_time=5
    start_capture(5);
    measure_expose(-1, width);
    check("width_ex5", width, 5);
    check_readout("cap5");

    // Clamp boundaries
    start_capture(0);
    measure_expose(-1, width);
    check("width_ex0", width, 2);
    check_readout("cap0");
    start_capture(31);
    measure_expose(-1, width);
    check("width_ex31", width, 30);
    check_readout("cap31");
    start_capture(30);
    measure_expose(-1, width);
    check("width_ex30", width, 30);
    check_readout("cap30");

    // Init held high yields one capture only
    start_capture(2);
    measure_expose(-1, width);
    check("width_hold", width, 2);
    check_readout("hold");
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Busy === 1'b1) cnt++;
      @(negedge clk);
    end
    check("hold_no_recapture", cnt, 0);

    // Drop Init one cycle, raise again: second capture
    start_capture(2);
    measure_expose(-1, width);
    check("width_second", width, 2);
    check_readout("second");

    // EX_time change mid-exposure is ignored
    start_capture(4);
    measure_expose(20, width);
    check("width_midchange", width, 4);
    check_readout("midchg");

    // Reset at readout step 5
    start_capture(2);
    measure_expose(-1, width);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("step5_strobes", int'({bus.NRE_1, bus.NRE_2, bus.ADC}), int'(3'b101));
    #1 reset = 1'b1;
    #1 check("reset_step5", outs(), int'(IDLE_VEC));
    bus.Init = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    start_capture(3);
    measure_expose(-1, width);
    check("width_after_reset", width, 3);
    check_readout("postrst");

`ifdef CAM_CTRL_ABORT_EN
    // Abort in IDLE has no effect
    bus.Abort = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", outs(), int'(IDLE_VEC));
    bus.Abort = 1'b0;

    // Abort at exposure cycle 3 of 10
    start_capture(10);
    repeat (3) @(negedge clk);
    check("abort_pre", outs(), int'(EXPOSE_VEC));
    bus.Abort = 1'b1;
    @(posedge clk); #1;
    bus.Abort = 1'b0;
    @(negedge clk);
    check("abort_idle_after", outs(), int'(IDLE_VEC));
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.NRE_1 !== 1'b1 || bus.NRE_2 !== 1'b1 || bus.Busy !== 1'b0) cnt++;
      @(negedge clk);
    end
    check("abort_no_readout", cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
